ram64x8_ctrl: RTL

Initiator-side controller for a ram64x8 instance; drives its ck/wen/addr/din port and consumes its dout.
- Write path: single-word writes accepted on a valid/ready interface.
- Scan path: on command, reads a contiguous, wrapping address window and streams the words out on a valid/ready read-data interface with backpressure.
- Replaces hand-sequenced bench/system access to the RAM with a cycle-exact master.

---
 rtl/ram64x8_pkg.sv | 28 ++
 rtl/ram64x8_scan_agen.sv | 45 ++++
 rtl/ram64x8_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram64x8_pkg.sv
// ram64x8_pkg: shared constants and types for the ram64x8 initiator-side
// controller (ram64x8_ctrl) and its scan address generator.
//   ADDR_W/DATA_W/DEPTH : RAM geometry (64 x 8)
//   RD_LAT_MAX          : largest supported RAM read latency
//   state_t             : controller FSM states
//   rd_word_t           : one captured scan word (address + data)
package ram64x8_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 64;
  localparam int RD_LAT_MAX = 4;
  localparam int LEN_W      = ADDR_W + 1;            // must hold DEPTH
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rd_word_t;

  // A programmed length of 0 selects the whole array.
  function automatic logic [LEN_W-1:0] scan_count(input logic [ADDR_W-1:0] len);
    return (len == '0) ? LEN_W'(DEPTH) : {1'b0, len};
  endfunction

endpackage

// File: rtl/ram64x8_scan_agen.sv
// ram64x8_scan_agen: scan window address generator.
// Holds the window base, word count and current word index.
//   ck, rst_n : clock, synchronous active-low reset
//   load      : latch base_in/len_in and restart at index 0
//   advance   : step to the next word of the window
//   base_in   : first address of the window
//   len_in    : word count, 0 means 64
//   addr      : (base + idx) mod 64, address of the current word
//   last      : current word is the final one of the window
module ram64x8_scan_agen
  import ram64x8_pkg::*;
(
  input  logic              ck,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] len_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;
  logic [LEN_W-1:0]  len;

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      base <= '0;
      len  <= '0;
      idx  <= '0;
    end else if (load) begin
      base <= base_in;
      len  <= scan_count(len_in);
      idx  <= '0;
    end else if (advance) begin
      idx  <= idx + ADDR_W'(1);
    end
  end

  // 6-bit addition wraps naturally at the top of the array.
  assign addr = base + idx;
  assign last = ({1'b0, idx} == (len - LEN_W'(1)));

endmodule

// File: rtl/ram64x8_ctrl.sv
// ram64x8_ctrl: initiator-side controller for a ram64x8 instance.
// Accepts single-word writes and runs wrapping address-window scans,
// streaming the read words out on a valid/ready interface.
// Optional build macro RAM64X8_CTRL_SCAN_SUM_EN adds scan_sum, the mod-256
// sum of all words handshaken in the current scan.
// Ports:
//   ck, rst_n                          : clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data  : write request channel
//   scan_start/scan_base/scan_len      : scan command (len 0 = 64 words)
//   busy                               : controller not idle
//   rd_valid/rd_ready/rd_data/rd_addr/rd_last : scanned word stream
//   scan_done                          : one-cycle pulse after final handshake
//   ram_wen/ram_addr/ram_din/ram_dout  : RAM port (outputs registered)
//   scan_sum (optional)                : running sum of the current scan
module ram64x8_ctrl
  import ram64x8_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scan_start,
  input  logic [ADDR_W-1:0] scan_base,
  input  logic [ADDR_W-1:0] scan_len,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              scan_done,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef RAM64X8_CTRL_SCAN_SUM_EN
  ,
  output logic [DATA_W-1:0] scan_sum
`endif
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  lat_cnt;
  logic              lat_done;
  logic              start_fire, wr_fire, hs;
  logic [ADDR_W-1:0] agen_addr;
  logic              agen_last;
  rd_word_t          word;

  assign start_fire = (state == IDLE) && scan_start;
  assign wr_fire    = wr_valid && wr_ready;
  assign hs         = rd_valid && rd_ready;
  assign lat_done   = (lat_cnt == CNT_W'(RD_LAT - 1));

  ram64x8_scan_agen u_agen (
    .ck      (ck),
    .rst_n   (rst_n),
    .load    (start_fire),
    .advance (hs),
    .base_in (scan_base),
    .len_in  (scan_len),
    .addr    (agen_addr),
    .last    (agen_last)
  );

  // State register
  always_ff @(posedge ck) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (scan_start) state_nx = RD_ISSUE;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  if (lat_done) state_nx = RD_HOLD;
      RD_HOLD:  if (rd_ready) state_nx = agen_last ? DONE : RD_ISSUE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State-decoded outputs. wr_ready is also held low while reset is
  // asserted so no write can slip in on a reset edge.
  always_comb begin
    wr_ready  = rst_n && (state == IDLE) && !scan_start;
    busy      = (state != IDLE);
    rd_valid  = (state == RD_HOLD);
    rd_last   = (state == RD_HOLD) && agen_last;
    scan_done = (state == DONE);
  end

  // RAM port, latency counter and captured word
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      ram_wen  <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      lat_cnt  <= '0;
      word     <= '0;
    end else begin
      ram_wen <= wr_fire;
      // ram_addr is registered, so the next read address is loaded on the
      // edge that enters RD_ISSUE (scan start or a non-final handshake).
      if (wr_fire) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end else if (start_fire) begin
        ram_addr <= scan_base;
      end else if (hs && !agen_last) begin
        ram_addr <= agen_addr + ADDR_W'(1);
      end

      lat_cnt <= (state == RD_WAIT) ? lat_cnt + CNT_W'(1) : '0;

      if ((state == RD_WAIT) && lat_done) begin
        word.data <= ram_dout;
        word.addr <= ram_addr;
      end
    end
  end

  assign rd_data = word.data;
  assign rd_addr = word.addr;

`ifdef RAM64X8_CTRL_SCAN_SUM_EN
  always_ff @(posedge ck) begin
    if (!rst_n)          scan_sum <= '0;
    else if (start_fire) scan_sum <= '0;
    else if (hs)         scan_sum <= scan_sum + rd_data;
  end
`endif

endmodule
